// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the PS/2 lines, validates frames, tracks F0/E0 prefixes,
// keeps a held-key bitmap and queues make/break events in a first-word-fall-through FIFO.
module ps2_key_decoder #(
    parameter int FILTER_LEN      = 4,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int FIFO_DEPTH      = 8,
    parameter bit PASS_ALL        = 1'b0,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [15:0] ev_data,
    output logic [3:0]  ev_key_id,
    output logic [10:0] key_held,
    output logic [7:0]  frame_err_count,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    FLEN_M1  = 4'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_STOP} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] map_key(input logic ext, input logic [7:0] code);
        logic [3:0] id;
        case ({ext, code})
            9'h01C:  id = 4'd1;
            9'h023:  id = 4'd2;
            9'h01D:  id = 4'd3;
            9'h01B:  id = 4'd4;
            9'h029:  id = 4'd5;
            9'h05A:  id = 4'd6;
            9'h076:  id = 4'd7;
            9'h16B:  id = 4'd8;
            9'h174:  id = 4'd9;
            9'h175:  id = 4'd10;
            9'h172:  id = 4'd11;
            default: id = 4'd0;
        endcase
        return id;
    endfunction

    // ---- Synchroniser and glitch filter ----
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       filt_clk_q;
    logic [3:0] filt_cnt_q;
    logic       strobe_q;
    logic       flip_d;
    logic       sdata;

    assign sdata  = data_sync_q[1];
    assign flip_d = (clk_sync_q[1] != filt_clk_q) && (filt_cnt_q == FLEN_M1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= 4'd0;
            strobe_q    <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            strobe_q    <= flip_d && filt_clk_q;
            if (clk_sync_q[1] == filt_clk_q) begin
                filt_cnt_q <= 4'd0;
            end else if (flip_d) begin
                filt_clk_q <= ~filt_clk_q;
                filt_cnt_q <= 4'd0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 4'd1;
            end
        end
    end

    // ---- Frame FSM (strobe cycle E -> byte_ok_q at E+1) ----
    state_t        state_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          byte_ok_q;
    logic          frame_bad_q;
    logic [7:0]    byte_q;
    logic [7:0]    err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_ok_q   <= 1'b0;
            frame_bad_q <= 1'b0;
            byte_q      <= 8'd0;
            err_q       <= 8'd0;
        end else begin
            byte_ok_q   <= 1'b0;
            frame_bad_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (strobe_q && !sdata) begin
                        state_q   <= S_RECV;
                        bit_cnt_q <= 4'd0;
                        tmo_q     <= '0;
                    end
                end
                S_RECV, S_STOP: begin
                    if (strobe_q) begin
                        tmo_q <= '0;
                        if (state_q == S_RECV) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q < 4'd8) begin
                                shift_q <= {sdata, shift_q[7:1]};
                            end else begin
                                par_q   <= sdata;
                                state_q <= S_STOP;
                            end
                        end else begin
                            // Odd parity over data+parity, and the stop bit must be high.
                            if ((^{shift_q, par_q}) && sdata) begin
                                byte_ok_q <= 1'b1;
                                byte_q    <= shift_q;
                            end else begin
                                frame_bad_q <= 1'b1;
                                err_q       <= sat_inc(err_q);
                            end
                            state_q <= S_IDLE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ---- Prefix tracking and key mapping (E+1 -> E+2) ----
    logic       ext_q;
    logic       brk_q;
    logic       cm_valid_q;
    logic       cm_brk_q;
    logic       cm_ext_q;
    logic [7:0] cm_code_q;
    logic [3:0] cm_id_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            cm_valid_q <= 1'b0;
            cm_brk_q   <= 1'b0;
            cm_ext_q   <= 1'b0;
            cm_code_q  <= 8'd0;
            cm_id_q    <= 4'd0;
        end else begin
            cm_valid_q <= 1'b0;
            if (frame_bad_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_ok_q) begin
                if (byte_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    cm_valid_q <= 1'b1;
                    cm_brk_q   <= brk_q;
                    cm_ext_q   <= ext_q;
                    cm_code_q  <= byte_q;
                    cm_id_q    <= map_key(ext_q, byte_q);
                    ext_q      <= 1'b0;
                    brk_q      <= 1'b0;
                end
            end
        end
    end

    // ---- Commit: held bitmap and FIFO push (E+2 -> E+3) ----
    logic [10:0] held_q;
    logic        mapped;
    logic        held_hit;
    logic        push;

    assign mapped   = (cm_id_q != 4'd0);
    assign held_hit = mapped && held_q[cm_id_q - 4'd1];
    assign push     = cm_valid_q && (mapped || PASS_ALL)
                      && !(SUPPRESS_REPEAT && !cm_brk_q && held_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q <= 11'd0;
        end else if (cm_valid_q && mapped) begin
            held_q[cm_id_q - 4'd1] <= !cm_brk_q;
        end
    end

    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic [15:0] data_mem [FIFO_DEPTH];
    logic [3:0]  id_mem   [FIFO_DEPTH];
    logic        ovf_q;
    logic        empty;
    logic        full;
    logic        pop;
    logic        do_push;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = !empty && ev_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            if (push && !do_push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_q[AW-1:0]] <= {cm_brk_q, 6'd0, cm_ext_q, cm_code_q};
            id_mem[wr_q[AW-1:0]]   <= cm_id_q;
        end
    end

    assign ev_valid        = !empty;
    assign ev_data         = empty ? 16'd0 : data_mem[rd_q[AW-1:0]];
    assign ev_key_id       = empty ? 4'd0  : id_mem[rd_q[AW-1:0]];
    assign key_held        = held_q;
    assign frame_err_count = err_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus randomized frames compared with a
// byte-level model of prefixes, held keys and the event queue.
module tb_ps2_key_decoder;
    localparam int HALF  = 15;
    localparam int TMO   = 2000;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ev_ready = 1'b1;
    logic        ev_valid;
    logic [15:0] ev_data;
    logic [3:0]  ev_key_id;
    logic [10:0] key_held;
    logic [7:0]  frame_err_count;
    logic        overflow;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH),
        .PASS_ALL(1'b0), .SUPPRESS_REPEAT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .ev_key_id(ev_key_id),
        .key_held(key_held), .frame_err_count(frame_err_count), .overflow(overflow)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: key table, prefix flags, held bitmap, error count, expected events
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  id;
    } ev_t;

    logic [8:0] key_tab [11] = '{9'h01C, 9'h023, 9'h01D, 9'h01B, 9'h029, 9'h05A, 9'h076,
                                 9'h16B, 9'h174, 9'h175, 9'h172};
    bit          m_ext, m_brk, m_ovf;
    logic [10:0] m_held;
    int          m_err;
    ev_t         q[$];

    function automatic int lookup(input bit ext, input logic [7:0] code);
        for (int i = 0; i < 11; i++)
            if (key_tab[i] == {ext, code}) return i + 1;
        return 0;
    endfunction

    task automatic model_clear();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_held = '0; m_err = 0;
        q.delete();
    endtask

    task automatic model_byte(input logic [7:0] code, input bit bad);
        int  id;
        bit  do_push;
        ev_t e;
        if (bad) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_ext = 0; m_brk = 0;
        end else if (code == 8'hE0) begin
            m_ext = 1;
        end else if (code == 8'hF0) begin
            m_brk = 1;
        end else begin
            id = lookup(m_ext, code);
            do_push = (id != 0) && !(!m_brk && m_held[id-1]);
            if (id != 0) m_held[id-1] = !m_brk;
            if (do_push) begin
                if (q.size() >= DEPTH) m_ovf = 1;
                else begin
                    e.data = {m_brk, 6'd0, m_ext, code};
                    e.id   = 4'(id);
                    q.push_back(e);
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Consumer-side scoreboard: every accepted head must match the next expected event
    always @(negedge clk) begin
        if (ev_valid && ev_ready) begin
            if (q.size() == 0) begin
                check("ev_unexpected_pending", 32'(q.size()), 32'd1);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("ev_data", {16'd0, ev_data}, {16'd0, e.data});
                check("ev_key_id", {28'd0, ev_key_id}, {28'd0, e.id});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                             input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (glitch) begin
                wait_clk(6); ps2_clk = 1'b0; wait_clk(1); ps2_clk = 1'b1; wait_clk(HALF - 7);
            end else wait_clk(HALF);
            ps2_clk = 1'b0;
            if (glitch) begin
                wait_clk(6); ps2_clk = 1'b1; wait_clk(1); ps2_clk = 1'b0; wait_clk(HALF - 7);
            end else wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] code, input bit bad_par = 0, input bit bad_stop = 0,
                        input bit glitch = 0);
        model_byte(code, bad_par | bad_stop);
        send_bits(code, bad_par, bad_stop, 11, glitch);
        wait_clk(30);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_held"}, {21'd0, key_held}, {21'd0, m_held});
        check({tag, "_err"}, {24'd0, frame_err_count}, 32'(m_err));
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, {31'd0, ev_valid}, 32'd0);
        check({tag, "_data"}, {16'd0, ev_data}, 32'd0);
        check({tag, "_id"}, {28'd0, ev_key_id}, 32'd0);
        check({tag, "_held"}, {21'd0, key_held}, 32'd0);
        check({tag, "_err"}, {24'd0, frame_err_count}, 32'd0);
        check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check_outputs_zero("reset");
        model_clear();
        wait_clk(3);
        reset = 1'b0;
        wait_clk(5);
    endtask

    initial begin
        model_clear();
        wait_clk(3);
        check_outputs_zero("por");
        reset = 1'b0;
        wait_clk(5);

        // Make/break of A
        send(8'h1C);
        check_state("a_make");
        send(8'hF0); send(8'h1C);
        check_state("a_break");

        // Extended UP make/break, then plain 75 which is unmapped
        send(8'hE0); send(8'h75);
        check_state("up_make");
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h75);
        check_state("up_break");

        // Parity error, then F0 with bad stop bit, then 23 decodes as a make
        send(8'h23, 1, 0);
        check_state("par_err");
        send(8'hF0, 0, 1);
        send(8'h23);
        check_state("stop_err");

        // Glitchy clock, then a partial frame left to time out
        send(8'h1B, 0, 0, 1);
        check_state("glitch");
        send_bits(8'h1D, 0, 0, 5, 0);
        wait_clk(TMO + 200);
        send(8'h1D);
        check_state("timeout");

        // Typematic repeat suppression
        send(8'h29); send(8'h29); send(8'h29); send(8'hF0); send(8'h29);
        check_state("repeat");
        check("drain1", 32'(q.size()), 32'd0);

        // Reset in the middle of a frame
        send_bits(8'h5A, 0, 0, 4, 0);
        do_reset();
        send(8'h5A);
        check_state("after_rst");
        check("drain2", 32'(q.size()), 32'd0);

        // FIFO fill with nine makes while the consumer stalls
        do_reset();
        ev_ready = 1'b0;
        send(8'h1C); send(8'h23); send(8'h1D); send(8'h1B); send(8'h29);
        send(8'h5A); send(8'h76); send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
        check_state("fifo_full");
        check("fifo_valid", {31'd0, ev_valid}, 32'd1);
        check("fifo_queued", 32'(q.size()), 32'(DEPTH));
        ev_ready = 1'b1;
        wait_clk(20);
        check("fifo_drain", 32'(q.size()), 32'd0);
        check("fifo_empty", {31'd0, ev_valid}, 32'd0);
        check_state("fifo_after");

        // Randomized frames with random stalls, glitches and frame errors
        for (int n = 0; n < 60; n++) begin
            int          sel;
            logic [7:0]  code;
            bit          bp, bs;
            if (n % 8 == 0) begin
                ev_ready = ($urandom_range(0, 3) != 0);
                wait_clk(20);
            end
            sel = $urandom_range(0, 15);
            if (sel <= 10) code = key_tab[sel][7:0];
            else if (sel <= 12) code = 8'hE0;
            else if (sel <= 14) code = 8'hF0;
            else code = 8'($urandom);
            bp = ($urandom_range(0, 11) == 0);
            bs = ($urandom_range(0, 11) == 0);
            send(code, bp, bs, ($urandom_range(0, 3) == 0));
            check_state("rand");
        end
        ev_ready = 1'b1;
        wait_clk(30);
        check("final_drain", 32'(q.size()), 32'd0);
        check_state("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Parametrised PS/2 keyboard front end for the game. It replaces the single-code keyboard decoder with a system-clock-domain receiver that does the following:
- synchronises and filters the PS/2 lines;
- checks each frame's start, parity and stop bits;
- tracks the F0 (break) and E0 (extended) prefixes;
- keeps a per-key held bitmap;
- queues make/break events in a FIFO with a valid/ready handshake.

It sits between the PS/2 pins and the CPU/game I/O register block.

Parameters:
FILTER_LEN, 4, consecutive identical synchronised ps2_clk samples required before the filtered clock changes (1..15)
TIMEOUT_CYCLES, 50000, system clocks with no falling edge mid-frame before the partial frame is discarded
FIFO_DEPTH, 8, event FIFO entries; power of 2, >=2
PASS_ALL, 0, 1 = enqueue every decoded code (key_id 0 if unmapped); 0 = enqueue mapped keys only
SUPPRESS_REPEAT, 1, 1 = a make for a key already held is not enqueued (typematic repeat dropped)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock, asynchronous
ps2_data  input  1  raw PS/2 data, asynchronous
ev_valid  output  1  FIFO head valid
ev_ready  input  1  consumer accepts head when ev_valid & ev_ready
ev_data  output  16  [15]=break, [8]=extended, [7:0]=scan code, other bits 0
ev_key_id  output  4  mapped key id of head (0 = unmapped)
key_held  output  11  bit (id-1) high while key id is held
frame_err_count  output  8  saturating count of rejected frames
overflow  output  1  sticky; set when a push is dropped because the FIFO is full

Behaviour:
- Reset (async, active-high) clears all of the following: sync/filter state (filtered clock = 1), bit counter, prefix flags, FIFO pointers, ev_valid, ev_data, ev_key_id, key_held, frame_err_count and overflow.
- Reset mid-frame discards the partial frame.
- Input conditioning: 2-FF synchroniser on both lines. The filtered ps2_clk toggles only after FILTER_LEN equal consecutive samples. A falling edge of the filtered clock is a one-cycle strobe; ps2_data (synchronised) is sampled on that strobe.
- Frame FSM states:
  - IDLE: a strobe with data=0 -> RECV; a strobe with data=1 -> stay IDLE, no error.
  - RECV: shift 8 data bits LSB first, then parity -> STOP.
  - STOP: on the stop strobe, check parity (odd: XOR of 8 data bits and parity bit = 1) and stop = 1, then -> IDLE.
- Frame failure: on a bad frame, frame_err_count increments (saturating at 255), F0/E0 flags clear and nothing is decoded.
- Timeout: a counter reloads on each strobe while in RECV/STOP. On reaching TIMEOUT_CYCLES it returns to IDLE with no error count.
- Byte valid: byte_ok pulses the cycle after a good stop strobe (E+1).
- Decode at E+1:
  - E0 sets ext; F0 sets brk; neither is enqueued.
  - Any other code forms an event {brk, ext, code}, then both flags clear.
- Key map (id: code):
  - 1:1C A, 2:23 D, 3:1D W, 4:1B S, 5:29 SPACE, 6:5A ENTER, 7:76 ESC
  - 8:E0 6B LEFT, 9:E0 74 RIGHT, 10:E0 75 UP, 11:E0 72 DOWN
  - The ext bit must match for a hit.
- Event commit at E+2: key_held[id-1] sets on make and clears on break. This is independent of FIFO state and of SUPPRESS_REPEAT. A break for a key not held is still enqueued.
- Push condition: mapped, or PASS_ALL=1.
- Push suppression: if SUPPRESS_REPEAT=1 and it is a make with key_held already set, no push.
- FIFO:
  - First-word-fall-through; ev_valid high from E+3 for an empty FIFO.
  - Pop on ev_valid & ev_ready.
  - Push when full: drop the new event and set overflow, unless a pop occurs in the same cycle, in which case both succeed.
  - Push and pop on an empty FIFO: the push lands and ev_valid rises next cycle.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- ev_data and ev_key_id are stable while ev_valid & !ev_ready.

Test Plan:
- Good frame 1C then F0 1C, ev_ready=1 -> events 0x001C/id1 then 0x801C/id1; key_held[0] goes 1 then 0.
- E0 75, E0 F0 75 -> 0x0175/id10 then 0x8175/id10; key_held[9] pulse. Plain 75 with PASS_ALL=0 -> no event.
- Parity error on 0x23 -> frame_err_count=1, no event, key_held unchanged. A following F0 with a bad stop bit, then 0x23 -> treated as a make, not a break.
- 1-cycle glitches on ps2_clk with FILTER_LEN=4 -> no extra bits. Stopping after 5 bits for >TIMEOUT_CYCLES, then a clean 1D -> id3 event, err count 0.
- ev_ready=0, 9 distinct makes with FIFO_DEPTH=8 -> 8 queued, overflow=1, 9th dropped, key_held still updated. Then drain -> events in order.
- SUPPRESS_REPEAT=1: 29,29,29,F0 29 -> exactly two events (make, break). Assert reset during a frame -> all outputs 0, next frame decodes normally.
